// File: rtl/flash_prog_ctrl.sv
// SPI flash erase/program sequencer with a 256-byte page buffer.
// CPU side: iomem bus (buffer, ADDR, CMD, STATUS). Flash side: byte-exchange SPI engine.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   iomem_valid/ready           request / one-cycle acknowledge
//   iomem_wstrb/addr/wdata      byte strobes (0 = read), byte address, write data
//   iomem_rdata                 registered read data, valid with iomem_ready
//   spi_start/tx/last           one-cycle byte request, byte to send, release CS after
//   spi_done/rx                 one-cycle completion pulse, received byte
module flash_prog_ctrl #(
    parameter logic [19:0] POLL_LIMIT = 20'd1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    output logic        spi_last,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_OPC,
        S_A2,
        S_A1,
        S_A0,
        S_DATA,
        S_PCMD,
        S_PRD
    } state_t;

    state_t      state_q, state_d;
    logic        kick_q, kick_d;
    logic        prog_q, prog_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [19:0] pcnt_q, pcnt_d;
    logic [23:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        start_q, start_d;
    logic [7:0]  tx_q, tx_d;
    logic        last_q, last_d;

    logic [7:0]  mem_q [256];

    logic        acc, wr_en, busy, go;
    logic [6:0]  widx;
    logic        is_buf, is_addr, is_cmd, is_stat;
    logic        buf_we;
    logic [1:0]  op_w;
    logic [31:0] rd_val;
    logic        unused_ok;

    assign unused_ok = ^{iomem_addr[31:9], iomem_addr[1:0], spi_rx[7:1]};

    // A new access is taken only while ready is low, so each access
    // occupies exactly two cycles.
    assign acc     = iomem_valid && !ready_q;
    assign wr_en   = acc && (iomem_wstrb != 4'd0);
    assign widx    = iomem_addr[8:2];
    assign busy    = (state_q != S_IDLE);
    assign is_buf  = !widx[6];
    assign is_addr = (widx == 7'h40);
    assign is_cmd  = (widx == 7'h41);
    assign is_stat = (widx == 7'h42);
    assign buf_we  = wr_en && is_buf && !busy;
    assign op_w    = iomem_wdata[1:0];

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign spi_start   = start_q;
    assign spi_tx      = tx_q;
    assign spi_last    = last_q;

    always_comb begin
        rd_val = 32'd0;
        unique case (1'b1)
            is_buf: rd_val = {mem_q[{widx[5:0], 2'd3}],
                              mem_q[{widx[5:0], 2'd2}],
                              mem_q[{widx[5:0], 2'd1}],
                              mem_q[{widx[5:0], 2'd0}]};
            is_addr: rd_val = {8'd0, addr_q};
            is_stat: rd_val = {29'd0, done_q, err_q, busy};
            default: rd_val = 32'd0;
        endcase
    end

    always_comb begin
        ready_d = acc;
        rdata_d = acc ? rd_val : rdata_q;
    end

    always_comb begin
        state_d = state_q;
        kick_d  = 1'b0;
        prog_d  = prog_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        done_d  = done_q;
        start_d = 1'b0;
        tx_d    = tx_q;
        last_d  = last_q;
        go      = 1'b0;

        if (wr_en && is_addr && !busy) begin
            for (int l = 0; l < 3; l++) begin
                if (iomem_wstrb[l]) addr_d[8*l +: 8] = iomem_wdata[8*l +: 8];
            end
        end

        if (wr_en && is_cmd && !busy && (op_w == 2'd1 || op_w == 2'd2)) begin
            state_d = S_WREN;
            kick_d  = 1'b1;
            prog_d  = op_w[1];
            len_d   = iomem_wdata[15:8];
            idx_d   = 8'd0;
            pcnt_d  = 20'd0;
            err_d   = 1'b0;
            done_d  = 1'b0;
        end

        // WREN is issued one cycle after the CMD write lands.
        if (kick_q) begin
            go = 1'b1;
        end else if (spi_done && busy) begin
            go = 1'b1;
            unique case (state_q)
                S_WREN: state_d = S_OPC;
                S_OPC:  state_d = S_A2;
                S_A2:   state_d = S_A1;
                S_A1:   state_d = S_A0;
                S_A0:   state_d = prog_q ? S_DATA : S_PCMD;
                S_DATA: begin
                    if (idx_q == len_q) state_d = S_PCMD;
                    else idx_d = idx_q + 8'd1;
                end
                S_PCMD: state_d = S_PRD;
                S_PRD: begin
                    pcnt_d = pcnt_q + 20'd1;
                    if (!spi_rx[0]) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        go      = 1'b0;
                    end else if (pcnt_q + 20'd1 == POLL_LIMIT) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        go      = 1'b0;
                    end else begin
                        state_d = S_PCMD;
                    end
                end
                default: go = 1'b0;
            endcase
        end

        if (go) begin
            start_d = 1'b1;
            unique case (state_d)
                S_WREN: begin tx_d = 8'h06; last_d = 1'b1; end
                S_OPC: begin
                    tx_d   = prog_q ? 8'h02 : 8'h20;
                    last_d = 1'b0;
                end
                S_A2: begin tx_d = addr_q[23:16]; last_d = 1'b0; end
                S_A1: begin tx_d = addr_q[15:8]; last_d = 1'b0; end
                S_A0: begin tx_d = addr_q[7:0]; last_d = !prog_q; end
                S_DATA: begin
                    tx_d   = mem_q[idx_d];
                    last_d = (idx_d == len_q);
                end
                S_PCMD: begin tx_d = 8'h05; last_d = 1'b0; end
                S_PRD: begin tx_d = 8'h00; last_d = 1'b1; end
                default: start_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            kick_q  <= 1'b0;
            prog_q  <= 1'b0;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            pcnt_q  <= 20'd0;
            addr_q  <= 24'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            start_q <= 1'b0;
            tx_q    <= 8'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kick_q  <= kick_d;
            prog_q  <= prog_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            start_q <= start_d;
            tx_q    <= tx_d;
            last_q  <= last_d;
        end
    end

    // Page buffer has no reset; contents are undefined until loaded.
    always_ff @(posedge clk) begin
        if (buf_we && iomem_wstrb[0]) mem_q[{widx[5:0], 2'd0}] <= iomem_wdata[7:0];
        if (buf_we && iomem_wstrb[1]) mem_q[{widx[5:0], 2'd1}] <= iomem_wdata[15:8];
        if (buf_we && iomem_wstrb[2]) mem_q[{widx[5:0], 2'd2}] <= iomem_wdata[23:16];
        if (buf_we && iomem_wstrb[3]) mem_q[{widx[5:0], 2'd3}] <= iomem_wdata[31:24];
    end

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Self-checking bench for flash_prog_ctrl: SPI engine model, byte-stream
// scoreboard built from the operation rules, and directed CPU scenarios.
`timescale 1ns/1ps
module tb_flash_prog_ctrl;

    localparam logic [19:0] LIM    = 20'd4;
    localparam logic [8:0]  A_ADDR = 9'h100;
    localparam logic [8:0]  A_CMD  = 9'h104;
    localparam logic [8:0]  A_STAT = 9'h108;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_last;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx = 8'd0;

    flash_prog_ctrl #(.POLL_LIMIT(LIM)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .spi_start   (spi_start),
        .spi_tx      (spi_tx),
        .spi_last    (spi_last),
        .spi_done    (spi_done),
        .spi_rx      (spi_rx)
    );

    typedef struct packed {
        logic [7:0] tx;
        logic       last;
        logic [7:0] rx;
    } xfer_t;

    xfer_t      expq[$];
    logic [7:0] pollq[$];
    logic [7:0] shadow [256];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         nstarts = 0;
    int         exp_start_cyc = -1;
    int         ack_cyc = 0;
    int         done_at = 0;
    bit         outstanding = 1'b0;
    bit         prev_ready = 1'b0;
    logic [7:0] cur_tx = 8'd0;
    logic [7:0] cur_rx = 8'd0;
    logic       cur_last = 1'b0;
    xfer_t      e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // SPI engine model and byte-stream scoreboard.
    always @(negedge clk) begin
        if (!resetn) begin
            expq.delete();
            outstanding = 1'b0;
            spi_done = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (spi_done) spi_done = 1'b0;
            if (iomem_ready) chk("ready_width", {31'd0, prev_ready}, 32'd0);
            prev_ready = iomem_ready;
            if (spi_start) begin
                nstarts++;
                if (expq.size() == 0 || outstanding) begin
                    chk("extra_start", {23'd0, spi_tx, spi_last}, 32'h1ff);
                end else begin
                    e = expq.pop_front();
                    chk("spi_byte", {23'd0, spi_tx, spi_last}, {23'd0, e.tx, e.last});
                    chk("start_cycle", cyc, exp_start_cyc);
                    cur_tx = spi_tx;
                    cur_last = spi_last;
                    cur_rx = e.rx;
                    outstanding = 1'b1;
                    done_at = cyc + 1 + (nstarts % 3);
                end
            end else if (outstanding) begin
                chk("spi_hold", {23'd0, spi_tx, spi_last}, {23'd0, cur_tx, cur_last});
            end else if (cyc == exp_start_cyc && expq.size() > 0) begin
                chk("start_missing", {31'd0, spi_start}, 32'd1);
            end
            if (outstanding && cyc == done_at) begin
                spi_done = 1'b1;
                spi_rx = cur_rx;
                outstanding = 1'b0;
                exp_start_cyc = cyc + 1;
            end
        end
    end

    task automatic bus(input logic [8:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] r);
        int n = 0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr = {23'd0, a};
        iomem_wstrb = s;
        iomem_wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!iomem_ready && n < 8);
        chk("bus_ack", {31'd0, iomem_ready}, 32'd1);
        r = iomem_rdata;
        ack_cyc = cyc;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [8:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        bus(a, s, d, r);
    endtask

    task automatic rd(input logic [8:0] a, output logic [31:0] r);
        bus(a, 4'd0, 32'd0, r);
    endtask

    task automatic wr_buf(input int w, input logic [3:0] s, input logic [31:0] d);
        wr(9'(w * 4), s, d);
        for (int l = 0; l < 4; l++) begin
            if (s[l]) shadow[w*4 + l] = d[8*l +: 8];
        end
    endtask

    function automatic void push(input logic [7:0] tx, input logic last, input logic [7:0] rx);
        xfer_t x;
        x.tx = tx;
        x.last = last;
        x.rx = rx;
        expq.push_back(x);
    endfunction

    // Expected byte stream and final STATUS, from the operation rules.
    task automatic start_op(input logic [1:0] op, input logic [23:0] a,
                            input int len, output logic [31:0] st_exp);
        st_exp = 32'hffff_ffff;
        wr(A_ADDR, 4'hf, {8'd0, a});
        push(8'h06, 1'b1, 8'h00);
        push((op == 2'd2) ? 8'h02 : 8'h20, 1'b0, 8'h00);
        push(a[23:16], 1'b0, 8'h00);
        push(a[15:8], 1'b0, 8'h00);
        push(a[7:0], op == 2'd1, 8'h00);
        if (op == 2'd2) begin
            for (int i = 0; i < len; i++) push(shadow[i], i == len - 1, 8'h00);
        end
        for (int i = 0; i < pollq.size(); i++) begin
            push(8'h05, 1'b0, 8'h00);
            push(8'h00, 1'b1, pollq[i]);
            if (!pollq[i][0]) begin
                st_exp = 32'h4;
                break;
            end
            if (i + 1 == int'(LIM)) begin
                st_exp = 32'h2;
                break;
            end
        end
        wr(A_CMD, 4'hf, {16'd0, 8'(len - 1), 6'd0, op});
        exp_start_cyc = ack_cyc + 1;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        int n = 0;
        do begin
            rd(A_STAT, st);
            n++;
        end while (st[0] && n < 3000);
        chk("op_finish", {31'd0, st[0]}, 32'd0);
    endtask

    task automatic finish_op(input string nm, input logic [31:0] st_exp, input int n0,
                             input int lit_bytes, input logic [31:0] lit_st);
        logic [31:0] st;
        wait_idle(st);
        chk({nm, "_status_model"}, st, st_exp);
        chk({nm, "_status_lit"}, st, lit_st);
        chk({nm, "_nbytes"}, nstarts - n0, lit_bytes);
        chk({nm, "_queue_drained"}, expq.size(), 32'd0);
    endtask

    task automatic set_polls(input int nbusy, input logic [7:0] busyv, input logic [7:0] fin);
        pollq.delete();
        for (int i = 0; i < nbusy; i++) pollq.push_back(busyv);
        pollq.push_back(fin);
    endtask

    initial begin
        logic [31:0] r, st_exp;
        int n0, n;

        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {iomem_ready, spi_start, spi_last, 21'd0, spi_tx},
            32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        resetn = 1'b1;
        rd(A_STAT, r);
        chk("rst_status", r, 32'd0);
        rd(A_ADDR, r);
        chk("rst_addr", r, 32'd0);

        // Sector erase, immediate completion.
        wr(A_ADDR, 4'hf, 32'hff01_2345);
        rd(A_ADDR, r);
        chk("addr_readback", r, 32'h0001_2345);
        rd(A_CMD, r);
        chk("cmd_reads_zero", r, 32'd0);
        set_polls(0, 8'h01, 8'h00);
        n0 = nstarts;
        start_op(2'd1, 24'h012345, 1, st_exp);
        finish_op("erase", st_exp, n0, 7, 32'h4);

        // Byte-lane strobes and 4-byte program.
        wr_buf(0, 4'hf, 32'h4433_2211);
        wr_buf(1, 4'hf, 32'h8877_6655);
        wr_buf(1, 4'b0101, 32'haabb_ccdd);
        rd(9'h004, r);
        chk("wstrb_merge", r, 32'h88bb_66dd);
        rd(9'h000, r);
        chk("buf_word0", r, 32'h4433_2211);
        rd(9'h1f0, r);
        chk("unmapped_read", r, 32'd0);
        set_polls(0, 8'h01, 8'h00);
        n0 = nstarts;
        start_op(2'd2, 24'h000100, 4, st_exp);
        finish_op("prog4", st_exp, n0, 11, 32'h4);

        // Full page, buffer byte i = i.
        for (int w = 0; w < 64; w++) begin
            wr_buf(w, 4'hf, {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)});
        end
        set_polls(0, 8'h01, 8'h00);
        n0 = nstarts;
        start_op(2'd2, 24'h10_0000, 256, st_exp);
        finish_op("page", st_exp, n0, 263, 32'h4);

        // WIP polling: three busy responses, then ready.
        set_polls(3, 8'h01, 8'h00);
        n0 = nstarts;
        start_op(2'd1, 24'h02_0000, 1, st_exp);
        finish_op("wip", st_exp, n0, 13, 32'h4);

        // Poll timeout at the limit.
        set_polls(6, 8'h03, 8'h03);
        n0 = nstarts;
        start_op(2'd1, 24'h03_0000, 1, st_exp);
        finish_op("timeout", st_exp, n0, 13, 32'h2);
        n0 = nstarts;
        repeat (20) @(negedge clk);
        chk("timeout_no_more_start", nstarts - n0, 32'd0);
        rd(A_STAT, r);
        chk("timeout_sticky", r, 32'h2);

        // Writes during DATA are acknowledged but ignored.
        set_polls(0, 8'h01, 8'h00);
        n0 = nstarts;
        start_op(2'd2, 24'h00_4400, 256, st_exp);
        n = 0;
        while (nstarts < n0 + 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        wr(9'h000, 4'hf, 32'hdead_beef);
        wr(A_ADDR, 4'hf, 32'h00ab_cdef);
        wr(A_CMD, 4'hf, 32'h0000_0001);
        rd(A_STAT, r);
        chk("busy_status", r, 32'h1);
        finish_op("busywr", st_exp, n0, 263, 32'h4);
        rd(9'h000, r);
        chk("busy_buf_kept", r, 32'h0302_0100);
        rd(A_ADDR, r);
        chk("busy_addr_kept", r, 32'h0000_4400);
        n0 = nstarts;
        repeat (20) @(negedge clk);
        chk("busy_no_extra_op", nstarts - n0, 32'd0);

        // Reset while the A1 byte is outstanding.
        set_polls(0, 8'h01, 8'h00);
        n0 = nstarts;
        start_op(2'd1, 24'h012345, 1, st_exp);
        n = 0;
        while (nstarts < n0 + 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_a1", nstarts - n0, 32'd4);
        chk("a1_tx", {24'd0, spi_tx}, 32'h23);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {iomem_ready, spi_start, spi_last, 21'd0, spi_tx},
            32'd0);
        chk("rst_mid_rdata", iomem_rdata, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        n0 = nstarts;
        rd(A_STAT, r);
        chk("rst_mid_status", r, 32'd0);
        rd(A_ADDR, r);
        chk("rst_mid_addr", r, 32'd0);
        repeat (30) @(negedge clk);
        chk("rst_mid_no_start", nstarts - n0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_prog_ctrl.md
# flash_prog_ctrl

Sequencer for programming the on-board SPI configuration flash from the soft CPU. It sits between the CPU iomem bus and a byte-exchange SPI engine. It holds a 256-byte page buffer and runs complete erase and program operations autonomously: WREN, opcode, 24-bit address, data, then status polling until WIP clears. The CPU only loads the buffer, writes ADDR and CMD, and polls STATUS.

## Interface
- POLL_LIMIT, 20'd1000000 — maximum RDSR polls before an operation aborts with error
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- iomem_valid  in  1  CPU request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address; only [8:2] decoded
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid with iomem_ready
- spi_start  out  1  one-cycle pulse: exchange one byte
- spi_tx  out  8  byte to send, stable from spi_start until spi_done
- spi_last  out  1  engine releases CS after this byte; stable with spi_tx
- spi_done  in  1  one-cycle pulse: byte exchange complete
- spi_rx  in  8  received byte, valid with spi_done

## Operation
- Register map (iomem_addr[8:2]):
  - 0x000–0x0FC: page buffer, 64×32 words, little-endian. Buffer byte i is word i/4, lane i%4. Writes honour wstrb per lane. Reads return the word.
  - 0x100 ADDR: [23:0] flash byte address. Reads return zero-extended value.
  - 0x104 CMD, write only:
    - [1:0] op: 1 = 4 KB sector erase (0x20), 2 = page program (0x02), 0/3 = no-op.
    - [15:8] len-1 for program: 0..255 gives 1..256 bytes.
    - Reads return 0.
  - 0x108 STATUS, read only:
    - bit0 busy.
    - bit1 error: poll timeout.
    - bit2 done: sticky; set on successful completion, cleared by any CMD write that starts an op.
  - Unmapped addresses read 0; writes to them are ignored.
- While busy, writes to buffer, ADDR and CMD are ignored but still acknowledged.
- CMD writing op 1/2 while idle: clears error and done, sets busy, enters WREN.
- FSM states and byte emitted:
  - IDLE.
  - WREN: 0x06, last=1.
  - OPC: 0x20 or 0x02, last=0.
  - A2, A1, A0: ADDR[23:16], [15:8], [7:0]. For erase, A0 has last=1. For program, last=0.
  - DATA (program only): buffer bytes 0..len-1. last=1 on byte len-1.
  - POLL_CMD: 0x05, last=0.
  - POLL_RD: 0x00, last=1.
- Transitions after POLL_RD's spi_done:
  - spi_rx[0]==0: IDLE, done=1, busy=0.
  - Else, if poll count reaches POLL_LIMIT: IDLE, error=1, busy=0, done unchanged at 0.
  - Else: POLL_CMD, count+1.
- Poll counter is 20 bits. It is cleared on entering WREN and counts completed POLL_RD bytes.
- Data index is 8 bits. It starts at 0 and is compared against len-1. There is no wrap past 255.
- Every other state advances on its spi_done.

## Timing
- iomem_ready rises the cycle after iomem_valid is sampled with iomem_ready low. It is high for exactly one cycle, so back-to-back accesses take two cycles each. iomem_rdata is registered in the same cycle.
- A CMD write acknowledged at cycle N puts busy=1 in STATUS from cycle N. spi_start for WREN pulses at cycle N+1.
- spi_done sampled at cycle M causes the next spi_start at M+1, with spi_tx and spi_last updated in the same cycle. Exactly one spi_start is outstanding at a time.
- spi_done arriving in IDLE is ignored.
- Reset values:
  - iomem_ready=0, iomem_rdata=0.
  - spi_start=0, spi_tx=0, spi_last=0.
  - FSM=IDLE; ADDR, status bits and counters 0.
  - Buffer contents undefined.
- Reset mid-operation returns to IDLE immediately. No further spi_start is issued. The flash transaction is left to the engine's own reset.

## Test plan
- Erase: ADDR=0x012345, CMD=0x1 → bytes 06(L), 20, 01, 23, 45(L), 05, 00(L) with spi_rx=0x00 → STATUS=0x4.
- Program 4 bytes: word0=0x44332211, ADDR=0x000100, CMD=0x0302 → bytes 06(L), 02, 00, 01, 00, 11, 22, 33, 44(L), 05, 00(L) → done.
- Full page: buffer byte i=i, len-1=0xFF → 256 data bytes 00..FF, last only on FF.
- WIP polling: POLL_RD spi_rx=0x01 three times then 0x00 → four 05/00 pairs, then STATUS=0x4.
- Timeout: POLL_LIMIT=4, spi_rx always 0x03 → four poll pairs, STATUS=0x2, no further spi_start.
- Busy and reset:
  - CMD and buffer writes during DATA are acknowledged but ignored; readback shows old buffer and no extra op.
  - resetn low during A1 → all outputs 0 next edge; STATUS reads 0 after release.
